// File: rtl/voice_allocator.sv
// voice_allocator
// ---------------
// Polyphonic voice scheduler for a bank of NUM_VOICES oscillators. Key events
// arrive over a valid/ready handshake. Each event is processed in three
// phases:
//   IDLE   - accept one event
//   SCAN   - examine one voice per cycle
//   COMMIT - apply the result
// Accepted events are therefore spaced NUM_VOICES+2 cycles apart.
//
// Note-on voice selection, in priority order:
//   1. retrigger a gated voice that already holds the key
//   2. otherwise use the lowest-index free (ungated) voice
//   3. otherwise steal the oldest gated voice
// Note-off releases every gated voice that holds the key.
//
// Build option:
//   VOICE_ALLOC_SUSTAIN_EN - adds the sustain input. While sustain is high,
//   note-offs only mark voices as pending-release. A falling edge of sustain
//   releases all pending voices.
//
// Ports:
//   clk         system clock (clk25 domain)
//   rst         synchronous active-high reset
//   sustain     sustain pedal (only with VOICE_ALLOC_SUSTAIN_EN)
//   ev_valid    event present
//   ev_ready    allocator can accept an event (registered)
//   ev_on       1 = note-on, 0 = note-off
//   ev_key      key number of the event; valid keys are 1..88
//   voice_key   key per voice; voice i is in bits [i*KEY_W +: KEY_W]
//   voice_gate  per-voice gate (voice sounding)
//   voice_load  one-cycle strobe that retriggers oscillator i
//   steal       one-cycle pulse, coincident with voice_load, when an active
//               voice was stolen
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                        sustain,
`endif
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0]       voice_load,
  output logic                        steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                  state_reg;
  logic                    ev_ready_reg;
  logic                    ev_on_reg;
  logic [KEY_W-1:0]        ev_key_reg;

  // Scan bookkeeping
  logic [IDX_W-1:0]        scan_idx_reg;
  logic                    match_found_reg;
  logic [IDX_W-1:0]        match_idx_reg;
  logic                    free_found_reg;
  logic [IDX_W-1:0]        free_idx_reg;
  logic                    oldest_found_reg;
  logic [IDX_W-1:0]        oldest_idx_reg;
  logic [AGE_W-1:0]        oldest_age_reg;
  logic [NUM_VOICES-1:0]   off_mask_reg;

  // Per-voice state
  logic [KEY_W-1:0]        key_reg [NUM_VOICES];
  logic [AGE_W-1:0]        age_reg [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_reg;
  logic [NUM_VOICES-1:0]   load_reg;
  logic                    steal_reg;

  logic                    key_ok;
  logic [IDX_W-1:0]        target_idx;
  logic                    target_steal;
  logic [NUM_VOICES-1:0]   release_mask;
  logic                    cur_gated;
  logic [KEY_W-1:0]        cur_key;
  logic [AGE_W-1:0]        cur_age;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic                    sus_reg;
  logic                    sus_d_reg;
  logic [NUM_VOICES-1:0]   pending_reg;
`endif

  // Keys outside 1..88 are consumed without any effect.
  assign key_ok = (ev_key_reg != '0) && (int'(ev_key_reg) <= 88);

  // Voice currently under examination in SCAN
  assign cur_gated = gate_reg[scan_idx_reg];
  assign cur_key   = key_reg[scan_idx_reg];
  assign cur_age   = age_reg[scan_idx_reg];

  // Note-on target selection: retrigger, then free voice, then steal oldest.
  // When no voice is free every voice is gated, so oldest is always valid.
  always_comb begin
    target_idx   = oldest_idx_reg;
    target_steal = 1'b1;
    if (match_found_reg) begin
      target_idx   = match_idx_reg;
      target_steal = 1'b0;
    end else if (free_found_reg) begin
      target_idx   = free_idx_reg;
      target_steal = 1'b0;
    end
  end

  // Voices released this cycle by a registered sustain falling edge
  always_comb begin
    release_mask = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    if (sus_d_reg && !sus_reg) begin
      release_mask = pending_reg;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      ev_ready_reg     <= 1'b0;
      ev_on_reg        <= 1'b0;
      ev_key_reg       <= '0;
      scan_idx_reg     <= '0;
      match_found_reg  <= 1'b0;
      match_idx_reg    <= '0;
      free_found_reg   <= 1'b0;
      free_idx_reg     <= '0;
      oldest_found_reg <= 1'b0;
      oldest_idx_reg   <= '0;
      oldest_age_reg   <= '0;
      off_mask_reg     <= '0;
      gate_reg         <= '0;
      load_reg         <= '0;
      steal_reg        <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_reg[v] <= '0;
        age_reg[v] <= '0;
      end
`ifdef VOICE_ALLOC_SUSTAIN_EN
      sus_reg     <= 1'b0;
      sus_d_reg   <= 1'b0;
      pending_reg <= '0;
`endif
    end else begin
      load_reg  <= '0;
      steal_reg <= 1'b0;

`ifdef VOICE_ALLOC_SUSTAIN_EN
      sus_reg   <= sustain;
      sus_d_reg <= sus_reg;
`endif

      // Sustain release runs in any state. It comes before the commit logic
      // so a same-cycle commit to the same voice overrides it.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (release_mask[v]) begin
          gate_reg[v] <= 1'b0;
          age_reg[v]  <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
          pending_reg[v] <= 1'b0;
`endif
        end
      end

      case (state_reg)
        IDLE: begin
          ev_ready_reg <= 1'b1;
          if (ev_valid && ev_ready_reg) begin
            ev_ready_reg     <= 1'b0;
            ev_on_reg        <= ev_on;
            ev_key_reg       <= ev_key;
            scan_idx_reg     <= '0;
            match_found_reg  <= 1'b0;
            match_idx_reg    <= '0;
            free_found_reg   <= 1'b0;
            free_idx_reg     <= '0;
            oldest_found_reg <= 1'b0;
            oldest_idx_reg   <= '0;
            oldest_age_reg   <= '0;
            off_mask_reg     <= '0;
            state_reg        <= SCAN;
          end
        end

        SCAN: begin
          if (cur_gated && (cur_key == ev_key_reg) && !match_found_reg) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= scan_idx_reg;
          end
          if (!cur_gated && !free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= scan_idx_reg;
          end
          // Strictly greater: ties keep the earlier (lower) index.
          if (cur_gated && (!oldest_found_reg || (cur_age > oldest_age_reg))) begin
            oldest_found_reg <= 1'b1;
            oldest_idx_reg   <= scan_idx_reg;
            oldest_age_reg   <= cur_age;
          end
          off_mask_reg[scan_idx_reg] <= cur_gated && (cur_key == ev_key_reg);
          if (scan_idx_reg == LAST_IDX) begin
            state_reg <= COMMIT;
          end else begin
            scan_idx_reg <= scan_idx_reg + 1'b1;
          end
        end

        COMMIT: begin
          state_reg    <= IDLE;
          ev_ready_reg <= 1'b1;
          if (key_ok && ev_on_reg) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (v == int'(target_idx)) begin
                key_reg[v]  <= ev_key_reg;
                gate_reg[v] <= 1'b1;
                age_reg[v]  <= '0;
                load_reg[v] <= 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                pending_reg[v] <= 1'b0;
`endif
              end else if (gate_reg[v] && !release_mask[v] && (age_reg[v] != '1)) begin
                age_reg[v] <= age_reg[v] + 1'b1;
              end
            end
            steal_reg <= target_steal;
          end else if (key_ok) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (off_mask_reg[v] && gate_reg[v]) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                if (sustain) begin
                  pending_reg[v] <= 1'b1;
                end else begin
                  gate_reg[v]    <= 1'b0;
                  age_reg[v]     <= '0;
                  pending_reg[v] <= 1'b0;
                end
`else
                gate_reg[v] <= 1'b0;
                age_reg[v]  <= '0;
`endif
              end
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Flatten the per-voice key array onto the output bus.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_key_out
      assign voice_key[gi*KEY_W +: KEY_W] = key_reg[gi];
    end
  endgenerate

  assign ev_ready   = ev_ready_reg;
  assign voice_gate = gate_reg;
  assign voice_load = load_reg;
  assign steal      = steal_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator (4 voices, 7-bit keys, 4-bit ages).
// Expected values are hand-computed from the allocation rules.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;
  localparam int AW = 4;

  logic             clk;
  logic             rst;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [KW-1:0]    ev_key;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0]    voice_gate;
  logic [NV-1:0]    voice_load;
  logic             steal;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic             sustain;
`endif

  int total_cnt;
  int bad_cnt;

  voice_allocator #(
    .NUM_VOICES(NV),
    .KEY_W     (KW),
    .AGE_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain   (sustain),
`endif
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_on     (ev_on),
    .ev_key    (ev_key),
    .voice_key (voice_key),
    .voice_gate(voice_gate),
    .voice_load(voice_load),
    .steal     (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] vkey(input int i);
    return voice_key[i*KW +: KW];
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    ev_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one event and follow it through to the cycle after COMMIT.
  // On return we are 1 time unit after the edge that produced voice_load.
  task automatic send_event(input string name, input logic on, input int key,
                            input logic [NV-1:0] exp_load, input logic exp_steal);
    bit got_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ev_ready) begin
        got_ready = 1;
        break;
      end
    end
    check({name, "_ready_wait"}, 32'(got_ready), 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = KW'(key);
    @(posedge clk);
    #1 ev_valid = 1'b0;
    check({name, "_ready_busy"}, 32'(ev_ready), 32'd0);
    repeat (NV) @(posedge clk);
    #1;
    check({name, "_load_early"}, 32'(voice_load), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_load"}, 32'(voice_load), 32'(exp_load));
    check({name, "_steal"}, 32'(steal), 32'(exp_steal));
    check({name, "_ready_back"}, 32'(ev_ready), 32'd1);
    $display("event %s on=%0b key=%0d load=%b steal=%b gate=%b",
             name, on, key, voice_load, steal, voice_gate);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    ev_valid  = 1'b0;
    ev_on     = 1'b0;
    ev_key    = '0;
    rst       = 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain   = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ev_ready), 32'd0);
    check("rst_gate", 32'(voice_gate), 32'd0);
    check("rst_load", 32'(voice_load), 32'd0);
    check("rst_steal", 32'(steal), 32'd0);
    check("rst_key", 32'(voice_key), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready_after", 32'(ev_ready), 32'd1);

    // First note-on goes to voice 0
    send_event("on49", 1'b1, 49, 4'b0001, 1'b0);
    check("on49_key0", 32'(vkey(0)), 32'd49);
    check("on49_gate", 32'(voice_gate), 32'b0001);
    @(posedge clk);
    #1;
    check("on49_load_once", 32'(voice_load), 32'd0);

    // Fill all voices, then steal the oldest one
    do_reset();
    send_event("on40", 1'b1, 40, 4'b0001, 1'b0);
    send_event("on41", 1'b1, 41, 4'b0010, 1'b0);
    send_event("on42", 1'b1, 42, 4'b0100, 1'b0);
    send_event("on43", 1'b1, 43, 4'b1000, 1'b0);
    check("full_gate", 32'(voice_gate), 32'b1111);
    send_event("on44", 1'b1, 44, 4'b0001, 1'b1);
    check("on44_key0", 32'(vkey(0)), 32'd44);
    @(posedge clk);
    #1;
    check("on44_steal_once", 32'(steal), 32'd0);

    // Retrigger an already-sounding key
    send_event("re41", 1'b1, 41, 4'b0010, 1'b0);
    check("re41_gate", 32'(voice_gate), 32'b1111);
    check("re41_key1", 32'(vkey(1)), 32'd41);

    // Note-off keeps the key for the release tail
    send_event("off41", 1'b0, 41, 4'b0000, 1'b0);
    check("off41_gate", 32'(voice_gate), 32'b1101);
    check("off41_key1", 32'(vkey(1)), 32'd41);
    send_event("off60", 1'b0, 60, 4'b0000, 1'b0);
    check("off60_gate", 32'(voice_gate), 32'b1101);

    // Invalid keys are consumed without effect
    send_event("on0", 1'b1, 0, 4'b0000, 1'b0);
    check("on0_gate", 32'(voice_gate), 32'b1101);
    send_event("on100", 1'b1, 100, 4'b0000, 1'b0);
    check("on100_gate", 32'(voice_gate), 32'b1101);
    check("on100_key0", 32'(vkey(0)), 32'd44);

    // Freed voice 1 is reused. Ages are now v0=2, v1=0, v2=4, v3=3.
    send_event("on50", 1'b1, 50, 4'b0010, 1'b0);
    check("on50_key1", 32'(vkey(1)), 32'd50);
    // The oldest voice is v2, so it is stolen rather than v0.
    send_event("on51", 1'b1, 51, 4'b0100, 1'b1);
    check("on51_key2", 32'(vkey(2)), 32'd51);
    check("on51_key0", 32'(vkey(0)), 32'd44);

    // Reset in the middle of a note-on scan
    begin
      int loads;
      loads = 0;
      @(negedge clk);
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_key   = 7'd60;
      @(posedge clk);
      #1 ev_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_gate", 32'(voice_gate), 32'd0);
      check("mid_rst_ready", 32'(ev_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_ready_after", 32'(ev_ready), 32'd1);
      for (int i = 0; i < NV + 4; i++) begin
        if (voice_load != '0) loads++;
        @(posedge clk);
        #1;
      end
      check("mid_rst_no_load", 32'(loads), 32'd0);
      $display("event mid_rst gate=%b ready=%b loads=%0d", voice_gate, ev_ready, loads);
    end

`ifdef VOICE_ALLOC_SUSTAIN_EN
    // Sustain holds the gate until the pedal is released
    do_reset();
    sustain = 1'b1;
    send_event("sus_on49", 1'b1, 49, 4'b0001, 1'b0);
    send_event("sus_off49", 1'b0, 49, 4'b0000, 1'b0);
    check("sus_hold_gate", 32'(voice_gate), 32'b0001);
    sustain = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sus_release_gate", 32'(voice_gate), 32'b0000);
    check("sus_release_key", 32'(vkey(0)), 32'd49);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
